serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking that diff and bout are updated.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit, the final borrow, which is 1 iff a < b.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at a clk edge, the block SHALL perform all of the following, then enter SHIFT:
- capture a and b into shift registers;
- clear the internal borrow flip-flop;
- clear the bit counter.
REQ-013 Each SHIFT cycle, the block SHALL process one bit pair, LSB first:
- d = a0 ^ b0 ^ br;
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
- d is shifted into the MSB of the working difference register;
- the operand registers shift right by one;
- the counter increments.
REQ-014 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE, copying the working register to diff and the final borrow to bout.
REQ-015 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-016 Latency: for start accepted at edge k, the block SHALL hold busy=1 during cycles k+1..k+WIDTH and done=1 during cycle k+WIDTH+1.
REQ-017 The block SHALL ignore start while in SHIFT or DONE, with no effect on the operation in flight.
REQ-018 The block SHALL keep diff and bout stable from one DONE until the next DONE, including during a later operation.
REQ-019 The block SHALL not sample a and b after the accepting edge; input changes during SHIFT SHALL have no effect.
REQ-020 Back-to-back use: a start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-021 The block SHALL keep the counter width at clog2(WIDTH)+1 so that it never wraps before the terminal count.

Reset
REQ-022 While rst_n=0, the block SHALL immediately, without waiting for clk, force all of the following:
- state = IDLE;
- busy = 0, done = 0;
- diff = 0, bout = 0;
- borrow flip-flop, counter and shift registers = 0.
REQ-023 If reset is asserted mid-operation, the block SHALL abandon the operation with no done pulse.
REQ-024 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-026 The per-bit datapath SHALL be one sub-module, full_subtractor (inputs x, y, bin; outputs d, bo), built from two half subtractors, with the borrow-out formed as the OR of their borrows.
REQ-027 The block SHALL instantiate exactly one full_subtractor; no ripple array is allowed.

Verification
REQ-028 Scenario, basic subtraction: WIDTH=8, a=10, b=3, start pulse -> done at cycle 9 after acceptance, diff=7, bout=0.
REQ-029 Scenario, underflow: a=3, b=10 -> diff=249, bout=1.
REQ-030 Scenario, boundary operands: a=0, b=0 -> diff=0, bout=0; a=0x00, b=0xFF -> diff=0x01, bout=1; a=0xFF, b=0x00 -> diff=0xFF, bout=0.
REQ-031 Scenario, start while busy: run a=20, b=5; assert start with a=1, b=2 during SHIFT -> single done with diff=15, bout=0, and busy pulse width unchanged.
REQ-032 Scenario, reset mid-operation: rst_n=0 at the 4th SHIFT cycle -> all outputs 0 immediately, no done; after release, a=100, b=1 -> diff=99.
REQ-033 Scenario, back-to-back: start on the first IDLE cycle after done with a=7, b=8 -> accepted, diff=255, bout=1, with the previous diff held until that second done.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, combinational: two cascaded half subtractors, borrow-out is the OR of both borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d = x ^ y;
  assign hs1_b = ~x & y;

  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bo = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: start accepted in IDLE, WIDTH busy cycles, then a one-cycle done.
// Latency WIDTH+1 cycles from acceptance to done; start is ignored while busy or done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Only the low WIDTH-1 result bits are kept; the MSB goes straight from the
  // subtractor into diff on the final shift cycle.
  logic [WIDTH-2:0] work_q, work_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic fs_d;
  logic fs_bo;

  full_subtractor u_fs (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (br_q),
    .d   (fs_d),
    .bo  (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        br_d             = fs_bo;
        cnt_d            = cnt_q + CW'(1);
        work_d           = work_q >> 1;
        work_d[WIDTH-2]  = fs_d;
        if (cnt_q == LAST_BIT) begin
          diff_d  = {fs_d, work_q};
          bout_d  = fs_bo;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
